// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, drives imem, buffers {pc, instr} and hands it to decode.
// Optional misaligned-redirect fault reporting is enabled with `define FETCH_MISALIGN_EN.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4
`ifdef FETCH_MISALIGN_EN
   ,
   output logic        fetch_fault,
   output logic [31:0] fault_pc
`endif
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fentry_t;

`ifdef FETCH_MISALIGN_EN
   typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;
`else
   typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

   state_t        state, state_nx;
   logic [31:0]   fetch_pc;
   fentry_t       fbuf [BUF_DEPTH];
   logic [PW-1:0] head, tail;
   logic [CW-1:0] count;
   fentry_t       hold;
   logic [31:0]   hold_p4;
   logic [31:0]   tgt;
   logic          redir_ok, misalign, pop, push;

   // masking keeps every redirect_pc bit in use even when the low bits are ignored
   assign tgt = redirect_pc & ~32'd3;

`ifdef FETCH_MISALIGN_EN
   assign misalign = |redirect_pc[1:0];
`else
   assign misalign = 1'b0;
`endif

   assign redir_ok  = redirect_valid & ~misalign;
   assign imem_addr = fetch_pc;
   assign if_valid  = (count != '0);
   assign pop       = if_valid & if_ready;
   assign push      = (state == RUN) & ~redirect_valid & ((count < DEPTH_C) | pop);

   // empty buffer replays the last presented head instead of stale storage
   assign if_pc       = if_valid ? fbuf[head].pc             : hold.pc;
   assign if_instr    = if_valid ? fbuf[head].instr          : hold.instr;
   assign if_pc_plus4 = if_valid ? fbuf[head].pc + 32'd4     : hold_p4;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = RUN;
         RUN:     state_nx = RUN;
         default: state_nx = state;
      endcase
      if (redirect_valid) begin
         state_nx = RUN;
`ifdef FETCH_MISALIGN_EN
         if (misalign) state_nx = FAULT;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc <= RESET_PC;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         hold     <= '0;
         hold_p4  <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) fbuf[i] <= '0;
      end else begin
         if (if_valid) begin
            hold    <= fbuf[head];
            hold_p4 <= fbuf[head].pc + 32'd4;
         end
         if (redir_ok)  fetch_pc <= tgt;
         else if (push) fetch_pc <= fetch_pc + 32'd4;
         if (push) fbuf[tail] <= '{pc: fetch_pc, instr: imem_rdata};
         // any redirect flushes; a same-cycle pop is squashed downstream
         if (redirect_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

`ifdef FETCH_MISALIGN_EN
   assign fetch_fault = (state == FAULT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                              fault_pc <= '0;
      else if (redirect_valid && misalign)   fault_pc <= redirect_pc;
   end
`endif

endmodule
